// File: rtl/flash_arb_pkg.sv
// Shared definitions for the flash bus arbiter.
// Contents: FSM state encoding, owner codes, parked-bus constants,
// and the watchdog counter width.
package flash_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OWN_PFL = 2'd1,
        ST_OWN_FC  = 2'd2,
        ST_TURN    = 2'd3
    } arb_state_e;

    localparam logic [1:0]  OWNER_NONE = 2'b00;
    localparam logic [1:0]  OWNER_PFL  = 2'b01;
    localparam logic [1:0]  OWNER_FC   = 2'b10;

    // Parked bus: all strobes deasserted (active-low), address at zero.
    localparam logic        CTRL_IDLE  = 1'b1;
    localparam logic [31:0] ADDR_PARK  = 32'd0;

    localparam int          WD_W       = 24;

endpackage

// File: rtl/flash_arb_wdog.sv
// Hold watchdog for the FC side of the flash bus.
// Ports:
//   clk, rst_n : clock and synchronous active-low reset
//   en         : count this cycle (FC owns the bus and PFL is waiting)
//   clr        : clear the count (has priority over en)
//   expire     : count has reached MAX
module flash_arb_wdog
    import flash_arb_pkg::*;
#(
    parameter logic [WD_W-1:0] MAX = {WD_W{1'b1}}
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic expire
);

    logic [WD_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)     cnt_d = '0;
        else if (en) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign expire = (cnt_q == MAX);

endmodule

// File: rtl/flash_bus_arbiter.sv
// Arbitrates the shared parallel-flash bus between the PFL configuration
// engine and the user flash controller (FC), with a parked turnaround gap
// between owners and a watchdog that revokes an FC grant held too long
// while PFL is waiting.
// Ports:
//   clkin_max_100, sys_resetn        : clock, synchronous active-low reset
//   pfl_req/pfl_gnt, pfl_addr/cen/oen/wen, pfl_rdata : PFL side
//   fc_req/fc_gnt, fc_addr/cen/oen/wen, fc_wdata(_oe), fc_rdata : FC side
//   flash_a/cen/oen/wen, fsm_d_out/oe, fsm_d_in : flash pins / data tristate
//   owner       : 00 none, 01 PFL, 10 FC
//   timeout_err : sticky, set when the watchdog revokes the FC grant
module flash_bus_arbiter
    import flash_arb_pkg::*;
#(
    parameter int              ADDR_W   = 25,
    parameter int              DATA_W   = 16,
    parameter int              TURN_CYC = 4,
    parameter logic [WD_W-1:0] HOLD_MAX = 24'hFFFFFF
) (
    input  logic              clkin_max_100,
    input  logic              sys_resetn,
    input  logic              pfl_req,
    output logic              pfl_gnt,
    input  logic [ADDR_W-1:0] pfl_addr,
    input  logic              pfl_cen,
    input  logic              pfl_oen,
    input  logic              pfl_wen,
    output logic [DATA_W-1:0] pfl_rdata,
    input  logic              fc_req,
    output logic              fc_gnt,
    input  logic [ADDR_W-1:0] fc_addr,
    input  logic              fc_cen,
    input  logic              fc_oen,
    input  logic              fc_wen,
    input  logic [DATA_W-1:0] fc_wdata,
    input  logic              fc_wdata_oe,
    output logic [DATA_W-1:0] fc_rdata,
    output logic [ADDR_W-1:0] flash_a,
    output logic              flash_cen,
    output logic              flash_oen,
    output logic              flash_wen,
    output logic [DATA_W-1:0] fsm_d_out,
    output logic              fsm_d_oe,
    input  logic [DATA_W-1:0] fsm_d_in,
    output logic [1:0]        owner,
    output logic              timeout_err
);

    arb_state_e state_q, state_d;
    logic [3:0] turn_cnt_q, turn_cnt_d;
    logic       fc_armed_q, fc_armed_d;
    logic       timeout_q, timeout_d;
    logic       wd_en, wd_expire;

    // Count only while FC holds the bus and PFL is waiting; any other cycle
    // clears, which also guarantees a zero count on entering OWN_FC.
    assign wd_en = (state_q == ST_OWN_FC) && pfl_req;

    flash_arb_wdog #(.MAX(HOLD_MAX)) u_wdog (
        .clk    (clkin_max_100),
        .rst_n  (sys_resetn),
        .en     (wd_en),
        .clr    (!wd_en),
        .expire (wd_expire)
    );

    always_comb begin
        state_d    = state_q;
        turn_cnt_d = turn_cnt_q;
        timeout_d  = timeout_q;
        fc_armed_d = fc_armed_q;
        // A revoked FC must be seen idle before it may be granted again.
        if (!fc_req) fc_armed_d = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (pfl_req)                  state_d = ST_OWN_PFL;
                else if (fc_req && fc_armed_q) state_d = ST_OWN_FC;
            end
            ST_OWN_PFL: begin
                if (!pfl_req) begin
                    state_d    = ST_TURN;
                    turn_cnt_d = '0;
                end
            end
            ST_OWN_FC: begin
                if (wd_expire) begin
                    state_d    = ST_TURN;
                    turn_cnt_d = '0;
                    timeout_d  = 1'b1;
                    fc_armed_d = 1'b0;
                end else if (!fc_req) begin
                    state_d    = ST_TURN;
                    turn_cnt_d = '0;
                end
            end
            ST_TURN: begin
                if (turn_cnt_q == 4'(TURN_CYC - 1)) begin
                    state_d    = ST_IDLE;
                    turn_cnt_d = '0;
                end else begin
                    turn_cnt_d = turn_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clkin_max_100) begin
        if (!sys_resetn) begin
            state_q    <= ST_IDLE;
            turn_cnt_q <= '0;
            fc_armed_q <= 1'b1;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            turn_cnt_q <= turn_cnt_d;
            fc_armed_q <= fc_armed_d;
            timeout_q  <= timeout_d;
        end
    end

    // Pin mux keyed on registered state only, so a request edge can never
    // glitch the pins ahead of the grant.
    always_comb begin
        flash_a   = ADDR_PARK[ADDR_W-1:0];
        flash_cen = CTRL_IDLE;
        flash_oen = CTRL_IDLE;
        flash_wen = CTRL_IDLE;
        fsm_d_out = '0;
        fsm_d_oe  = 1'b0;
        owner     = OWNER_NONE;
        case (state_q)
            ST_OWN_PFL: begin
                flash_a   = pfl_addr;
                flash_cen = pfl_cen;
                flash_oen = pfl_oen;
                flash_wen = pfl_wen;
                owner     = OWNER_PFL;
            end
            ST_OWN_FC: begin
                flash_a   = fc_addr;
                flash_cen = fc_cen;
                flash_oen = fc_oen;
                flash_wen = fc_wen;
                fsm_d_out = fc_wdata;
                fsm_d_oe  = fc_wdata_oe;
                owner     = OWNER_FC;
            end
            default: ;
        endcase
    end

    assign pfl_gnt     = (state_q == ST_OWN_PFL);
    assign fc_gnt      = (state_q == ST_OWN_FC);
    assign pfl_rdata   = fsm_d_in;
    assign fc_rdata    = fsm_d_in;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_flash_bus_arbiter.sv
module tb_flash_bus_arbiter;

    localparam int          ADDR_W = 25;
    localparam int          DATA_W = 16;
    localparam int          TC     = 4;
    localparam int          HM     = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              pfl_req = 0, pfl_cen = 1, pfl_oen = 1, pfl_wen = 1;
    logic [ADDR_W-1:0] pfl_addr = '0;
    logic              fc_req = 0, fc_cen = 1, fc_oen = 1, fc_wen = 1, fc_wdata_oe = 0;
    logic [ADDR_W-1:0] fc_addr = '0;
    logic [DATA_W-1:0] fc_wdata = '0, fsm_d_in = '0;
    logic              pfl_gnt, fc_gnt, flash_cen, flash_oen, flash_wen, fsm_d_oe, timeout_err;
    logic [DATA_W-1:0] pfl_rdata, fc_rdata, fsm_d_out;
    logic [ADDR_W-1:0] flash_a;
    logic [1:0]        owner;

    flash_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TURN_CYC(TC), .HOLD_MAX(24'(HM))) dut (
        .clkin_max_100(clk), .sys_resetn(rst_n),
        .pfl_req(pfl_req), .pfl_gnt(pfl_gnt), .pfl_addr(pfl_addr),
        .pfl_cen(pfl_cen), .pfl_oen(pfl_oen), .pfl_wen(pfl_wen), .pfl_rdata(pfl_rdata),
        .fc_req(fc_req), .fc_gnt(fc_gnt), .fc_addr(fc_addr),
        .fc_cen(fc_cen), .fc_oen(fc_oen), .fc_wen(fc_wen),
        .fc_wdata(fc_wdata), .fc_wdata_oe(fc_wdata_oe), .fc_rdata(fc_rdata),
        .flash_a(flash_a), .flash_cen(flash_cen), .flash_oen(flash_oen), .flash_wen(flash_wen),
        .fsm_d_out(fsm_d_out), .fsm_d_oe(fsm_d_oe), .fsm_d_in(fsm_d_in),
        .owner(owner), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit chk_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: who owns the bus, how many parked cycles remain,
    // how long PFL has been kept waiting, and the sticky/arming flags.
    int m_own   = 0;   // 0 none, 1 PFL, 2 FC
    int m_gap   = 0;   // parked cycles still to run before arbitration
    int m_hold  = 0;
    bit m_armed = 1;
    bit m_err   = 0;
    bit m_rev;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_own = 0; m_gap = 0; m_hold = 0; m_armed = 1; m_err = 0;
        end else begin
            m_rev = 0;
            if (m_own == 1) begin
                if (!pfl_req) begin m_own = 0; m_gap = TC; end
            end else if (m_own == 2) begin
                if (m_hold == HM) begin
                    m_rev = 1; m_err = 1; m_armed = 0; m_own = 0; m_gap = TC;
                end else if (!fc_req) begin
                    m_own = 0; m_gap = TC;
                end else begin
                    m_hold = pfl_req ? m_hold + 1 : 0;
                end
            end else if (m_gap > 0) begin
                m_gap--;
            end else if (pfl_req) begin
                m_own = 1;
            end else if (fc_req && m_armed) begin
                m_own = 2; m_hold = 0;
            end
            if (!m_rev && !fc_req) m_armed = 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [ADDR_W-1:0] ea;
            logic [2:0]        ec;
            logic [DATA_W-1:0] ed;
            logic              eoe;
            ea = '0; ec = 3'b111; ed = '0; eoe = 0;
            if (m_own == 1) begin
                ea = pfl_addr; ec = {pfl_cen, pfl_oen, pfl_wen};
            end else if (m_own == 2) begin
                ea = fc_addr; ec = {fc_cen, fc_oen, fc_wen}; ed = fc_wdata; eoe = fc_wdata_oe;
            end
            chk("owner", 32'(owner), 32'(m_own));
            chk("gnt", {30'd0, pfl_gnt, fc_gnt}, {30'd0, m_own == 1, m_own == 2});
            chk("flash_a", 32'(flash_a), 32'(ea));
            chk("ctrl", {29'd0, flash_cen, flash_oen, flash_wen}, {29'd0, ec});
            chk("d_out", {15'd0, fsm_d_oe, fsm_d_out}, {15'd0, eoe, ed});
            chk("rdata", {pfl_rdata, fc_rdata}, {fsm_d_in, fsm_d_in});
            chk("timeout_err", 32'(timeout_err), 32'(m_err));
        end
    end

    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int n;
        cyc(3);
        chk_en = 1;
        rst_n  = 1;
        #1;
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_cen", 32'(flash_cen), 32'd1);
        chk("rst_err", 32'(timeout_err), 32'd0);

        // FC write ownership
        fc_addr = 25'h0A5F00; fc_wdata = 16'h1234; fc_wdata_oe = 1;
        fc_cen = 0; fc_wen = 0; fc_req = 1;
        cyc();
        chk("fc_gnt_lat", 32'(fc_gnt), 32'd1);
        chk("fc_addr_pin", 32'(flash_a), 32'h0A5F00);
        chk("fc_oe_on", 32'(fsm_d_oe), 32'd1);
        chk("fc_dout", 32'(fsm_d_out), 32'h1234);
        fc_wdata_oe = 0; #1;
        chk("fc_oe_off", 32'(fsm_d_oe), 32'd0);
        fc_req = 0;
        cyc();
        chk("fc_release", {30'd0, fc_gnt, flash_cen}, 32'b01);
        cyc(TC);

        // Simultaneous requests: PFL wins, FC follows after the gap
        pfl_req = 1; fc_req = 1;
        cyc();
        chk("prio", {30'd0, pfl_gnt, fc_gnt}, 32'b10);
        pfl_oen = 0; pfl_cen = 0; pfl_addr = 25'h1ABCDE; fsm_d_in = 16'hBEEF; fc_wdata_oe = 1;
        #1;
        chk("pfl_rdata", 32'(pfl_rdata), 32'hBEEF);
        chk("pfl_d_oe", 32'(fsm_d_oe), 32'd0);
        chk("pfl_oen_pin", 32'(flash_oen), 32'd0);
        fc_req = 0; cyc(); fc_req = 1; cyc();
        chk("fc_toggle_pfl", 32'(owner), 32'd1);
        pfl_req = 0;
        cyc();
        for (int k = 0; k < TC; k++) begin
            chk("turn_parked", {29'd0, flash_cen, pfl_gnt, fc_gnt}, 32'b100);
            cyc();
        end
        chk("idle_gap", 32'(owner), 32'd0);
        cyc();
        chk("fc_after_turn", 32'(fc_gnt), 32'd1);

        // Watchdog revoke
        pfl_req = 1;
        n = 1;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (fc_gnt) n++;
            else break;
        end
        chk("wd_hold_cycles", 32'(n), 32'd17);
        chk("wd_err", 32'(timeout_err), 32'd1);
        cyc(TC + 1);
        chk("pfl_after_revoke", 32'(pfl_gnt), 32'd1);
        pfl_req = 0;
        cyc(10);
        chk("fc_not_rearmed", 32'(fc_gnt), 32'd0);
        fc_req = 0; cyc(); fc_req = 1; cyc();
        chk("fc_rearmed", 32'(fc_gnt), 32'd1);

        // PFL pulse clears the hold count
        pfl_req = 1; cyc(10);
        pfl_req = 0; cyc();
        pfl_req = 1; cyc(10);
        chk("wd_cleared", 32'(fc_gnt), 32'd1);

        // Reset mid FC write
        pfl_req = 0; fc_wdata_oe = 1; fc_wen = 0; cyc();
        chk("pre_rst_oe", 32'(fsm_d_oe), 32'd1);
        rst_n = 0;
        cyc();
        chk("rst_mid", {27'd0, owner, fsm_d_oe, flash_cen, timeout_err}, 32'b00010);
        rst_n = 1;
        cyc();
        chk("rst_armed", 32'(fc_gnt), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 11) == 0) pfl_req = ~pfl_req;
            if ($urandom_range(0, 7) == 0)  fc_req = ~fc_req;
            pfl_addr = ADDR_W'($urandom); fc_addr = ADDR_W'($urandom);
            {pfl_cen, pfl_oen, pfl_wen} = 3'($urandom);
            {fc_cen, fc_oen, fc_wen, fc_wdata_oe} = 4'($urandom);
            fc_wdata = DATA_W'($urandom); fsm_d_in = DATA_W'($urandom);
            rst_n = ($urandom_range(0, 299) != 0);
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
